// File: rtl/axis_rr_packet_arbiter.sv
// Round-robin, packet-locked AXI-Stream arbiter with one output register stage.
// A grant is held from the first beat until its tlast beat is accepted.
module axis_rr_packet_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_SRC    = 4,
  localparam int IDX_W     = $clog2(NUM_SRC)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  output logic                          m_axis_tlast,
  input  logic                          m_axis_tready,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;

  logic                  out_ready;
  logic                  hs;
  logic                  hs_last;
  logic [DATA_WIDTH-1:0] lane;
  logic                  pick_found;
  logic [IDX_W-1:0]      pick_idx;

  // Output register can take a beat when empty or draining this cycle.
  assign out_ready = !tvalid_q || m_axis_tready;
  assign lane      = s_axis_tdata[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
  assign hs        = (state_q == LOCKED)
                   && s_axis_tvalid[grant_q]
                   && out_ready;
  assign hs_last   = hs && s_axis_tlast[grant_q];

  // Search starts at rr_ptr and wraps, so the lowest offset wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      int cand;
      cand = (int'(rr_ptr_q) + k) % NUM_SRC;
      if (!pick_found && s_axis_tvalid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = LOCKED;
          grant_d = pick_idx;
        end
      end
      LOCKED: begin
        if (hs_last) begin
          state_d = IDLE;
          if (grant_q == IDX_W'(NUM_SRC - 1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = grant_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_axis_tready = '0;
    busy          = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy = 1'b0;
      end
      LOCKED: begin
        busy                   = 1'b1;
        s_axis_tready[grant_q] = out_ready;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Output stage drains on its own, independent of the FSM.
  always_comb begin
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    if (hs) begin
      tdata_d  = lane;
      tlast_d  = s_axis_tlast[grant_q];
      tvalid_d = 1'b1;
    end else if (m_axis_tready) begin
      tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else begin
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign grant_idx     = grant_q;

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Bench for axis_rr_packet_arbiter: directed scenarios plus a random phase,
// checked cycle by cycle against a transaction-style reference model.
module tb_axis_rr_packet_arbiter;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int IW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N-1:0]  s_axis_tvalid;
  logic [N-1:0]  s_axis_tlast;
  logic [N-1:0]  s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic [IW-1:0] grant_idx;
  logic          busy;

  always #5 clk = ~clk;

  axis_rr_packet_arbiter #(.DATA_WIDTH(DW), .NUM_SRC(N)) dut (
    .clk(clk),
    .reset(reset),
    .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .grant_idx(grant_idx),
    .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  // Per-source beat queues: {last, data}.
  logic [8:0] src_q [N][$];
  bit         pres [N];
  bit         gap_en;

  // Reference model: owner = -1 means no packet in progress.
  int         owner;
  int         ptr;
  int         gidx;
  bit         ov;
  bit         ol;
  logic [7:0] od;

  logic [8:0] obs_q[$];
  logic [8:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic model_reset();
    owner = -1;
    ptr   = 0;
    gidx  = 0;
    ov    = 1'b0;
    ol    = 1'b0;
    od    = '0;
    for (int s = 0; s < N; s++) begin
      src_q[s].delete();
      pres[s] = 1'b0;
    end
    obs_q.delete();
  endtask

  task automatic drive(input bit mr);
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_tdata  = '0;
    for (int s = 0; s < N; s++) begin
      if (!pres[s] && src_q[s].size() > 0
          && (!gap_en || $urandom_range(0, 2) != 0))
        pres[s] = 1'b1;
      if (pres[s]) begin
        s_axis_tvalid[s]          = 1'b1;
        s_axis_tlast[s]           = src_q[s][0][8];
        s_axis_tdata[s*DW +: DW]  = src_q[s][0][7:0];
      end
    end
    m_axis_tready = mr;
  endtask

  task automatic step(input bit mr);
    logic [N-1:0] etr;
    bit           hs;
    int           o;
    @(negedge clk);
    drive(mr);
    #1;
    etr = '0;
    if (owner >= 0 && (!ov || mr)) etr[owner] = 1'b1;
    chk("tready", 32'(s_axis_tready), 32'(etr));
    chk("m_tvalid", 32'(m_axis_tvalid), 32'(ov));
    chk("m_tdata", 32'(m_axis_tdata), 32'(od));
    chk("m_tlast", 32'(m_axis_tlast), 32'(ol));
    chk("busy", 32'(busy), 32'(owner >= 0));
    chk("grant_idx", 32'(grant_idx), 32'(gidx));
    if (m_axis_tvalid && m_axis_tready)
      obs_q.push_back({m_axis_tlast, m_axis_tdata});
    o  = owner;
    hs = (o >= 0) && pres[o] && etr[o];
    if (hs) begin
      od = src_q[o][0][7:0];
      ol = src_q[o][0][8];
      ov = 1'b1;
    end else if (mr) begin
      ov = 1'b0;
    end
    if (o < 0) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (ptr + k) % N;
        if (owner < 0 && pres[c]) begin
          owner = c;
          gidx  = c;
        end
      end
    end else if (hs) begin
      if (src_q[o][0][8]) begin
        owner = -1;
        ptr   = (o + 1) % N;
      end
      void'(src_q[o].pop_front());
      pres[o] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset         = 1'b1;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_tdata  = '0;
    #1;
    chk("rst_tready", 32'(s_axis_tready), 32'h0);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'h0);
    chk("rst_tdata", 32'(m_axis_tdata), 32'h0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_gidx", 32'(grant_idx), 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push_pkt(input int s, input logic [7:0] base,
                          input int len);
    for (int b = 0; b < len; b++)
      src_q[s].push_back({(b == len - 1), base + 8'(b)});
  endtask

  task automatic chk_obs(input string tag);
    chk({tag, "_len"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk(tag, 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  initial begin
    reset         = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    m_axis_tready = 1'b0;
    gap_en        = 1'b0;
    model_reset();
    #12;
    do_reset();

    // Reset while locked with a pending output beat.
    push_pkt(0, 8'h10, 4);
    repeat (3) step(1'b1);
    chk("pre_rst_ov", 32'(m_axis_tvalid), 32'h1);
    do_reset();
    push_pkt(1, 8'h20, 1);
    push_pkt(0, 8'h30, 1);
    repeat (8) step(1'b1);
    exp_q = '{9'h130, 9'h120};
    chk_obs("post_rst_order");

    // Single source, three beats.
    do_reset();
    push_pkt(1, 8'hA1, 3);
    repeat (7) step(1'b1);
    exp_q = '{9'h0A1, 9'h0A2, 9'h1A3};
    chk_obs("single_src");
    chk("single_gidx", 32'(grant_idx), 32'h1);

    // All four sources contending, src0 with a second packet.
    do_reset();
    push_pkt(0, 8'h00, 2);
    push_pkt(0, 8'h02, 2);
    push_pkt(1, 8'h10, 2);
    push_pkt(2, 8'h20, 2);
    push_pkt(3, 8'h30, 2);
    repeat (20) step(1'b1);
    exp_q = '{9'h000, 9'h101, 9'h010, 9'h111, 9'h020, 9'h121,
              9'h030, 9'h131, 9'h002, 9'h103};
    chk_obs("rr_order");

    // Wrap-around after src3.
    do_reset();
    push_pkt(3, 8'h30, 1);
    repeat (2) step(1'b1);
    push_pkt(2, 8'h20, 1);
    push_pkt(0, 8'h00, 1);
    repeat (8) step(1'b1);
    exp_q = '{9'h130, 9'h100, 9'h120};
    chk_obs("wrap");

    // Backpressure with 0x55 pending.
    do_reset();
    push_pkt(2, 8'h54, 3);
    repeat (3) step(1'b1);
    repeat (3) begin
      step(1'b0);
      chk("bp_data", 32'(m_axis_tdata), 32'h55);
      chk("bp_tready2", 32'(s_axis_tready[2]), 32'h0);
    end
    repeat (5) step(1'b1);
    exp_q = '{9'h054, 9'h055, 9'h156};
    chk_obs("backpressure");

    // Interleave guard: src1 single-beat waits for src0's packet.
    do_reset();
    push_pkt(0, 8'h00, 3);
    push_pkt(1, 8'h11, 1);
    repeat (10) step(1'b1);
    exp_q = '{9'h000, 9'h001, 9'h102, 9'h111};
    chk_obs("interleave");

    // Random phase: gaps on sources, random downstream ready.
    do_reset();
    gap_en = 1'b1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int s = 0; s < N; s++)
        if (src_q[s].size() == 0 && $urandom_range(0, 3) == 0)
          push_pkt(s, 8'($urandom), int'($urandom_range(1, 4)));
      step(cyc >= 560 || $urandom_range(0, 3) != 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
